// File: rtl/clock_divider_pkg.sv
// Shared helpers and constants for the tick generator and the LED/scan blocks that use it.
// Counter width is derived here so every user of the divider sizes its debug count the same way.
package clock_divider_pkg;

    // Common divide ratios for a 100 MHz system clock
    localparam int DIV_1HZ   = 100_000_000;
    localparam int DIV_4HZ   = 25_000_000;
    localparam int DIV_1KHZ  = 100_000;

    // Width of a phase counter that must hold 0..div-1; never narrower than one bit
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Programmable tick generator: one-clk strobe every DIV_VALUE enabled clk cycles.
// No derived clock is produced; downstream logic stays on clk and qualifies with tick.
// Optional feature macro: CLOCK_DIVIDER_TOGGLE_EN adds a tick_tg square wave that flips
// on every tick. Without it tick_tg is a constant 0 and the port list is unchanged.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int DIV_VALUE = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    output logic                            tick,
    output logic [cnt_width(DIV_VALUE)-1:0] count,
    output logic                            tick_tg
);

    localparam int CNT_W = cnt_width(DIV_VALUE);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DIV_VALUE - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    // A divide ratio below one has no meaningful tick period
    generate
        if (DIV_VALUE < 1) begin : gParamCheck
            $error("clock_divider: DIV_VALUE must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // Next phase and strobe: advance only when enabled, wrap and strobe on the last phase
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (enable) begin
            if (count_q == LAST_PHASE) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Phase counter and registered strobe; reset discards any partial phase
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;

`ifdef CLOCK_DIVIDER_TOGGLE_EN
    logic tick_tg_q;

    // Flip on the same edge that raises tick, giving a 50% duty wave of period 2*DIV_VALUE
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_tg_q <= 1'b0;
        end else if (tick_d) begin
            tick_tg_q <= ~tick_tg_q;
        end
    end

    assign tick_tg = tick_tg_q;
`else
    assign tick_tg = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: a DIV_VALUE=10 instance for the main sequence and a
// DIV_VALUE=1 instance for the degenerate ratio. Expected values are hand-derived.
// Toggle output expectations follow CLOCK_DIVIDER_TOGGLE_EN.
module tb_clock_divider;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       tick;
    logic [3:0] count;
    logic       tickTg;

    logic       rst1;
    logic       enable1;
    logic       tick1;
    logic [0:0] count1;
    logic       tickTg1;

    int testCount;
    int failCount;
    int tickSeen;
    int toggles;

    clock_divider #(.DIV_VALUE(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .tick    (tick),
        .count   (count),
        .tick_tg (tickTg)
    );

    clock_divider #(.DIV_VALUE(1)) dut1 (
        .clk     (clk),
        .rst     (rst1),
        .enable  (enable1),
        .tick    (tick1),
        .count   (count1),
        .tick_tg (tickTg1)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected toggle level after a given number of ticks since reset
    function automatic logic expectedTg(input int nTicks);
`ifdef CLOCK_DIVIDER_TOGGLE_EN
        return nTicks[0];
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        testCount = 0;
        failCount = 0;
        rst     = 1'b1;
        enable  = 1'b1;
        rst1    = 1'b1;
        enable1 = 1'b0;

        // 1: reset dominates enable
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("rst_tick", 32'(tick), 32'd0);
            checkOutput("rst_count", 32'(count), 32'd0);
            checkOutput("rst_tg", 32'(tickTg), 32'd0);
        end

        // 2: free run 30 cycles, ticks after edges 10, 20, 30
        rst = 1'b0;
        tickSeen = 0;
        toggles = 0;
        for (int k = 1; k <= 30; k++) begin
            applyStimulus();
            if (k % 10 == 0) toggles++;
            checkOutput("run_count", 32'(count), 32'(k % 10));
            checkOutput("run_tick", 32'(tick), (k % 10 == 0) ? 32'd1 : 32'd0);
            checkOutput("run_tg", 32'(tickTg), 32'(expectedTg(toggles)));
            if (tick) tickSeen++;
        end
        checkOutput("run_tick_total", 32'(tickSeen), 32'd3);

        // 3: pause at phase 4, then resume; tick after 6 further enabled cycles
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            checkOutput("pre_pause_count", 32'(count), 32'(k));
        end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("pause_count", 32'(count), 32'd4);
            checkOutput("pause_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus();
            checkOutput("resume_count", 32'(count), 32'(4 + k));
            checkOutput("resume_tick", 32'(tick), 32'd0);
        end
        applyStimulus();
        toggles++;
        checkOutput("resume_wrap_count", 32'(count), 32'd0);
        checkOutput("resume_wrap_tick", 32'(tick), 32'd1);
        checkOutput("resume_wrap_tg", 32'(tickTg), 32'(expectedTg(toggles)));

        // 4: reset mid-count at phase 7 discards the phase
        for (int k = 0; k < 7; k++) applyStimulus();
        checkOutput("mid_count", 32'(count), 32'd7);
        rst = 1'b1;
        applyStimulus();
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_tg", 32'(tickTg), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            checkOutput("post_rst_tick", 32'(tick), (k == 10) ? 32'd1 : 32'd0);
            checkOutput("post_rst_count", 32'(count), 32'(k % 10));
        end
        checkOutput("post_rst_tg", 32'(tickTg), 32'(expectedTg(1)));

        // 5: DIV_VALUE=1 ticks every enabled cycle and stops right after enable drops
        rst1 = 1'b0;
        enable1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("div1_tick", 32'(tick1), 32'd1);
            checkOutput("div1_count", 32'(count1), 32'd0);
            checkOutput("div1_tg", 32'(tickTg1), 32'(expectedTg(k + 1)));
        end
        enable1 = 1'b0;
        applyStimulus();
        checkOutput("div1_off_tick", 32'(tick1), 32'd0);
        checkOutput("div1_off_count", 32'(count1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
